// File: rtl/spi_fl_sequencer_if.sv
// Request/response and spi_master_fl handshake bundle shared by the CPU-side
// controller, the command sequencer and the SPI flash master.
interface spi_fl_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [7:0]  req_data;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic [7:0]  spi_data_in;
    logic [23:0] spi_address;
    logic [7:0]  spi_command;
    logic        spi_validflag;
    logic        spi_tofrom_fl;
    logic [7:0]  spi_data_out;
    logic        spi_validflag_out;
    logic        spi_tready;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_addr, req_data,
        input  spi_data_out, spi_validflag_out, spi_tready,
        output req_ready, resp_valid, resp_data, resp_err,
        output spi_data_in, spi_address, spi_command, spi_validflag, spi_tofrom_fl
    );

    // CPU controller plus flash master environment
    modport master (
        output req_valid, req_op, req_addr, req_data,
        output spi_data_out, spi_validflag_out, spi_tready,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  spi_data_in, spi_address, spi_command, spi_validflag, spi_tofrom_fl
    );
endinterface

// File: rtl/spi_fl_sequencer.sv
module spi_fl_sequencer #(
    parameter logic [7:0]  CMD_READ = 8'h03,
    parameter logic [7:0]  CMD_WREN = 8'h06,
    parameter logic [7:0]  CMD_PP   = 8'h02,
    parameter logic [7:0]  CMD_SE   = 8'h20,
    parameter logic [7:0]  CMD_RDSR = 8'h05,
    parameter int unsigned WIP_BIT  = 0,
    parameter logic [15:0] POLL_MAX = 16'd4096
) (
    input  logic              clk,
    input  logic              rst,
    spi_fl_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_NEXT, S_RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_PROG  = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [1:0]  step_q;
    logic [23:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  cap_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [7:0]  resp_data_q;
    logic        vf_q;
    logic        tofrom_q;
    logic [7:0]  cmd_q;
    logic [23:0] spi_addr_q;
    logic [7:0]  din_q;
    logic        poll_limit;

`ifdef SPI_FL_SEQ_TIMEOUT_EN
    logic [15:0] poll_q;
    logic        resp_err_q;
    assign poll_limit   = (poll_q == POLL_MAX);
    assign bus.resp_err = resp_err_q;
`else
    assign poll_limit   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    logic [7:0]  step_cmd;
    logic        step_wr;
    logic        step_loop;
    logic        step_last;
    logic [23:0] step_addr;
    logic [7:0]  step_din;

    always_comb begin
        step_cmd  = CMD_RDSR;
        step_wr   = 1'b0;
        step_loop = 1'b0;
        step_last = 1'b1;
        step_addr = 24'd0;
        step_din  = 8'd0;
        case (op_q)
            OP_READ: begin
                step_cmd  = CMD_READ;
                step_addr = addr_q;
            end
            OP_PROG, OP_ERASE: begin
                case (step_q)
                    2'd0: begin
                        step_cmd  = CMD_WREN;
                        step_wr   = 1'b1;
                        step_last = 1'b0;
                    end
                    2'd1: begin
                        step_cmd  = (op_q == OP_PROG) ? CMD_PP : CMD_SE;
                        step_wr   = 1'b1;
                        step_last = 1'b0;
                        step_addr = addr_q;
                        step_din  = (op_q == OP_PROG) ? data_q : 8'd0;
                    end
                    default: step_loop = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            step_q       <= 2'd0;
            addr_q       <= 24'd0;
            data_q       <= 8'd0;
            cap_q        <= 8'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'd0;
            vf_q         <= 1'b0;
            tofrom_q     <= 1'b0;
            cmd_q        <= 8'd0;
            spi_addr_q   <= 24'd0;
            din_q        <= 8'd0;
`ifdef SPI_FL_SEQ_TIMEOUT_EN
            poll_q       <= 16'd0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            if (state_q != S_IDLE && bus.spi_validflag_out)
                cap_q <= bus.spi_data_out;

            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        addr_q      <= bus.req_addr;
                        data_q      <= bus.req_data;
                        step_q      <= 2'd0;
                        cap_q       <= 8'd0;
                        req_ready_q <= 1'b0;
`ifdef SPI_FL_SEQ_TIMEOUT_EN
                        poll_q      <= 16'd0;
`endif
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.spi_tready) begin
                        vf_q       <= 1'b1;
                        cmd_q      <= step_cmd;
                        tofrom_q   <= step_wr;
                        spi_addr_q <= step_addr;
                        din_q      <= step_din;
                        state_q    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    vf_q <= 1'b0;
                    if (!bus.spi_tready)
                        state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.spi_tready)
                        state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (step_loop && cap_q[WIP_BIT] && !poll_limit) begin
`ifdef SPI_FL_SEQ_TIMEOUT_EN
                        poll_q  <= poll_q + 16'd1;
`endif
                        state_q <= S_ISSUE;
                    end else if (step_last) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= cap_q;
`ifdef SPI_FL_SEQ_TIMEOUT_EN
                        resp_err_q   <= step_loop && cap_q[WIP_BIT];
`endif
                        state_q      <= S_RESP;
                    end else begin
                        step_q  <= step_q + 2'd1;
                        state_q <= S_ISSUE;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
`ifdef SPI_FL_SEQ_TIMEOUT_EN
                    resp_err_q   <= 1'b0;
`endif
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.spi_validflag = vf_q;
    assign bus.spi_tofrom_fl = tofrom_q;
    assign bus.spi_command   = cmd_q;
    assign bus.spi_address   = spi_addr_q;
    assign bus.spi_data_in   = din_q;
endmodule

// File: tb/tb_spi_fl_sequencer.sv
module tb_spi_fl_sequencer;
    logic clk;
    logic rst;

`ifdef SPI_FL_SEQ_TIMEOUT_EN
    localparam logic [15:0] TB_POLL_MAX = 16'd4;
`else
    localparam logic [15:0] TB_POLL_MAX = 16'd4096;
`endif

    spi_fl_sequencer_if bus();

    spi_fl_sequencer #(.POLL_MAX(TB_POLL_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    int          n_frames  = 0;
    int          n_rdsr    = 0;
    int          resp_cnt  = 0;
    int          vf_viol   = 0;
    int          hold_seen = 0;
    int          m_phase   = 0;
    int          m_cnt     = 0;
    logic        m_init    = 1'b0;
    logic        m_rd      = 1'b0;
    logic [7:0]  m_byte    = 8'h00;
    logic        vf_prev   = 1'b0;
    logic [7:0]  fr_cmd  [$];
    logic [23:0] fr_addr [$];
    logic [7:0]  fr_din  [$];
    logic        fr_wr   [$];

    int          wip_until;
    int          hold_len;
    int          hold_tok;
    logic [7:0]  rd_byte;

    always @(negedge clk) begin
        if (!m_init) begin
            bus.spi_tready   = 1'b1;
            bus.spi_data_out = 8'h00;
            m_init = 1'b1;
        end
        bus.spi_validflag_out = 1'b0;
        if (bus.spi_validflag === 1'b1 && bus.spi_tready !== 1'b1) vf_viol++;
        if (bus.spi_validflag === 1'b1 && vf_prev) vf_viol++;
        vf_prev = (bus.spi_validflag === 1'b1);
        if (bus.resp_valid === 1'b1) resp_cnt++;
        case (m_phase)
            0: begin
                if (bus.spi_validflag === 1'b1) begin
                    fr_cmd.push_back(bus.spi_command);
                    fr_addr.push_back(bus.spi_address);
                    fr_din.push_back(bus.spi_data_in);
                    fr_wr.push_back(bus.spi_tofrom_fl);
                    m_rd = !bus.spi_tofrom_fl;
                    if (bus.spi_command == 8'h05) begin
                        m_byte = (n_rdsr < wip_until) ? 8'h01 : 8'h00;
                        n_rdsr++;
                    end else begin
                        m_byte = rd_byte;
                    end
                    n_frames++;
                    m_cnt   = 0;
                    m_phase = 1;
                end else if (hold_tok != hold_seen) begin
                    hold_seen      = hold_tok;
                    bus.spi_tready = 1'b0;
                    m_cnt          = 0;
                    m_phase        = 2;
                end
            end
            1: begin
                m_cnt++;
                if (m_cnt == 2) bus.spi_tready = 1'b0;
                if (m_cnt == 4 && m_rd) begin
                    bus.spi_validflag_out = 1'b1;
                    bus.spi_data_out      = m_byte;
                end
                if (m_cnt == 6) begin
                    m_cnt = 0;
                    if (hold_len > 0) begin
                        m_phase = 2;
                    end else begin
                        bus.spi_tready = 1'b1;
                        m_phase        = 0;
                    end
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt >= hold_len) begin
                    bus.spi_tready = 1'b1;
                    m_phase        = 0;
                end
            end
        endcase
    end

    function automatic logic [40:0] frame_at(input int k);
        if (k < fr_cmd.size())
            return {fr_cmd[k], fr_addr[k], fr_din[k], fr_wr[k]};
        return 41'bx;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d);
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int budget, output logic got, output logic [7:0] d, output logic e);
        got = 1'b0;
        d   = 8'h00;
        e   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                got = 1'b1;
                d   = bus.resp_data;
                e   = bus.resp_err;
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = 24'd0;
        bus.req_data  = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.spi_validflag, bus.spi_tofrom_fl} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b expected %b",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.spi_validflag, bus.spi_tofrom_fl}, 5'b10000);
        else n_pass++;
        n_checks++;
        if ({bus.resp_data, bus.spi_command, bus.spi_address, bus.spi_data_in} !== 48'd0)
            $display("FAIL reset_data: got %h expected %h",
                     {bus.resp_data, bus.spi_command, bus.spi_address, bus.spi_data_in}, 48'd0);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int base;
        int rc;
        logic got;
        logic [7:0] d;
        logic e;
        base    = n_frames;
        rc      = resp_cnt;
        rd_byte = 8'hA5;
        do_req(2'd0, 24'h012345, 8'h00);
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL read_ready_drop: got %b expected 0", bus.req_ready);
        else n_pass++;
        wait_resp(300, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL read_resp_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'hA5, 1'b0}) $display("FAIL read_resp: got %h/%b expected a5/0", d, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10)
            $display("FAIL read_ready_back: got %b expected 10", {bus.req_ready, bus.resp_valid});
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_frames - base != 1) $display("FAIL read_nframes: got %0d expected 1", n_frames - base);
        else n_pass++;
        n_checks++;
        if (frame_at(base) !== {8'h03, 24'h012345, 8'h00, 1'b0})
            $display("FAIL read_frame: got %h expected %h", frame_at(base), {8'h03, 24'h012345, 8'h00, 1'b0});
        else n_pass++;
        n_checks++;
        if (resp_cnt - rc != 1) $display("FAIL read_resp_count: got %0d expected 1", resp_cnt - rc);
        else n_pass++;
    endtask

    task automatic test_program();
        int base;
        logic got;
        logic [7:0] d;
        logic e;
        logic [40:0] exp_fr [0:5];
        exp_fr[0] = {8'h06, 24'h000000, 8'h00, 1'b1};
        exp_fr[1] = {8'h02, 24'h000100, 8'h3C, 1'b1};
        for (int i = 2; i < 6; i++) exp_fr[i] = {8'h05, 24'h000000, 8'h00, 1'b0};
        base      = n_frames;
        wip_until = n_rdsr + 3;
        do_req(2'd1, 24'h000100, 8'h3C);
        wait_resp(600, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL prog_resp_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'h00, 1'b0}) $display("FAIL prog_resp: got %h/%b expected 00/0", d, e);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_frames - base != 6) $display("FAIL prog_nframes: got %0d expected 6", n_frames - base);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (frame_at(base + i) !== exp_fr[i])
                $display("FAIL prog_frame%0d: got %h expected %h", i, frame_at(base + i), exp_fr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_erase();
        int base;
        int rc;
        logic got;
        logic [7:0] d;
        logic e;
        logic [40:0] exp_fr [0:2];
        exp_fr[0] = {8'h06, 24'h000000, 8'h00, 1'b1};
        exp_fr[1] = {8'h20, 24'h001000, 8'h00, 1'b1};
        exp_fr[2] = {8'h05, 24'h000000, 8'h00, 1'b0};
        base      = n_frames;
        rc        = resp_cnt;
        wip_until = n_rdsr;
        do_req(2'd2, 24'h001000, 8'hEE);
        wait_resp(400, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL erase_resp_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'h00, 1'b0}) $display("FAIL erase_resp: got %h/%b expected 00/0", d, e);
        else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_frames - base != 3) $display("FAIL erase_nframes: got %0d expected 3", n_frames - base);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (frame_at(base + i) !== exp_fr[i])
                $display("FAIL erase_frame%0d: got %h expected %h", i, frame_at(base + i), exp_fr[i]);
            else n_pass++;
        end
        n_checks++;
        if (resp_cnt - rc != 1) $display("FAIL erase_resp_count: got %0d expected 1", resp_cnt - rc);
        else n_pass++;
    endtask

    task automatic test_rdsr_op();
        int base;
        logic got;
        logic [7:0] d;
        logic e;
        base      = n_frames;
        wip_until = n_rdsr + 1;
        do_req(2'd3, 24'hFFFFFF, 8'hFF);
        wait_resp(300, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL rdsr_resp_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'h01, 1'b0}) $display("FAIL rdsr_resp: got %h/%b expected 01/0", d, e);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_frames - base != 1) $display("FAIL rdsr_nframes: got %0d expected 1", n_frames - base);
        else n_pass++;
        n_checks++;
        if (frame_at(base) !== {8'h05, 24'h000000, 8'h00, 1'b0})
            $display("FAIL rdsr_frame: got %h expected %h", frame_at(base), {8'h05, 24'h000000, 8'h00, 1'b0});
        else n_pass++;
    endtask

    task automatic test_handshake();
        int base;
        int rc;
        logic got;
        logic [7:0] d;
        logic e;
        logic [40:0] exp_fr [0:3];
        exp_fr[0] = {8'h06, 24'h000000, 8'h00, 1'b1};
        exp_fr[1] = {8'h20, 24'h002000, 8'h00, 1'b1};
        exp_fr[2] = {8'h05, 24'h000000, 8'h00, 1'b0};
        exp_fr[3] = {8'h05, 24'h000000, 8'h00, 1'b0};
        base      = n_frames;
        rc        = resp_cnt;
        wip_until = n_rdsr + 1;
        hold_len  = 50;
        hold_tok++;
        repeat (2) @(negedge clk);
        do_req(2'd2, 24'h002000, 8'h00);
        bus.req_op    = 2'd0;
        bus.req_addr  = 24'h0F0F0F;
        bus.req_valid = 1'b1;
        repeat (20) @(negedge clk);
        bus.req_valid = 1'b0;
        wait_resp(3000, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL hs_resp_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'h00, 1'b0}) $display("FAIL hs_resp: got %h/%b expected 00/0", d, e);
        else n_pass++;
        repeat (60) @(negedge clk);
        hold_len = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (n_frames - base != 4) $display("FAIL hs_nframes: got %0d expected 4", n_frames - base);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (frame_at(base + i) !== exp_fr[i])
                $display("FAIL hs_frame%0d: got %h expected %h", i, frame_at(base + i), exp_fr[i]);
            else n_pass++;
        end
        n_checks++;
        if (vf_viol != 0) $display("FAIL hs_validflag_rule: got %0d violations expected 0", vf_viol);
        else n_pass++;
        n_checks++;
        if (resp_cnt - rc != 1) $display("FAIL hs_resp_count: got %0d expected 1", resp_cnt - rc);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int base;
        int base2;
        int rc;
        logic got;
        logic [7:0] d;
        logic e;
        base      = n_frames;
        rc        = resp_cnt;
        wip_until = n_rdsr;
        do_req(2'd1, 24'h000200, 8'h55);
        for (int i = 0; i < 300 && n_frames < base + 2; i++) @(negedge clk);
        n_checks++;
        if (frame_at(base + 1) !== {8'h02, 24'h000200, 8'h55, 1'b1})
            $display("FAIL midrst_pp_frame: got %h expected %h", frame_at(base + 1), {8'h02, 24'h000200, 8'h55, 1'b1});
        else n_pass++;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.spi_validflag} !== 3'b100)
            $display("FAIL midrst_outputs: got %b expected 100", {bus.req_ready, bus.resp_valid, bus.spi_validflag});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (resp_cnt != rc) $display("FAIL midrst_no_resp: got %0d expected %0d", resp_cnt, rc);
        else n_pass++;
        base2   = n_frames;
        rd_byte = 8'h5A;
        do_req(2'd0, 24'h0ABCDE, 8'h00);
        wait_resp(400, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL midrst_read_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'h5A, 1'b0}) $display("FAIL midrst_read_resp: got %h/%b expected 5a/0", d, e);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_frames - base2 != 1 || frame_at(base2) !== {8'h03, 24'h0ABCDE, 8'h00, 1'b0})
            $display("FAIL midrst_read_frame: got %0d frames, first %h expected 1, %h",
                     n_frames - base2, frame_at(base2), {8'h03, 24'h0ABCDE, 8'h00, 1'b0});
        else n_pass++;
    endtask

`ifdef SPI_FL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        logic got;
        logic [7:0] d;
        logic e;
        logic [40:0] exp_fr [0:6];
        exp_fr[0] = {8'h06, 24'h000000, 8'h00, 1'b1};
        exp_fr[1] = {8'h02, 24'h000300, 8'h77, 1'b1};
        for (int i = 2; i < 7; i++) exp_fr[i] = {8'h05, 24'h000000, 8'h00, 1'b0};
        base      = n_frames;
        wip_until = n_rdsr + 1000;
        do_req(2'd1, 24'h000300, 8'h77);
        wait_resp(1000, got, d, e);
        n_checks++;
        if (got !== 1'b1) $display("FAIL tmo_resp_seen: got %b expected 1", got);
        else n_pass++;
        n_checks++;
        if ({d, e} !== {8'h01, 1'b1}) $display("FAIL tmo_resp: got %h/%b expected 01/1", d, e);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_frames - base != 7) $display("FAIL tmo_nframes: got %0d expected 7", n_frames - base);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (frame_at(base + i) !== exp_fr[i])
                $display("FAIL tmo_frame%0d: got %h expected %h", i, frame_at(base + i), exp_fr[i]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        wip_until = 0;
        hold_len  = 0;
        hold_tok  = 0;
        rd_byte   = 8'h00;
        test_reset();
        test_read();
        test_program();
        test_erase();
        test_rdsr_op();
        test_handshake();
        test_reset_midop();
`ifdef SPI_FL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_fl_sequencer.md
Name: spi_fl_sequencer

Overview:
- Command sequencer in front of the SPI flash master (`spi_master_fl`).
- Accepts single high-level requests from the CPU-side controller: READ byte, PROGRAM byte, ERASE sector, READ STATUS.
- Expands each request into the required flash command sequence: write-enable, main command, then status polling until WIP clears.
- Drives the master's `validflag`/`tready` handshake and returns one response per request.

Parameters:
- CMD_READ, 8'h03, flash read opcode
- CMD_WREN, 8'h06, write-enable opcode
- CMD_PP, 8'h02, page-program opcode
- CMD_SE, 8'h20, sector-erase opcode
- CMD_RDSR, 8'h05, read-status opcode
- WIP_BIT, 0, status bit index meaning write-in-progress
- POLL_MAX, 16'd4096, maximum RDSR polls before timeout (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready
- req_op  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=RDSR
- req_addr  in  24  flash byte/sector address
- req_data  in  8  program data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  8  read byte (READ) or final status byte (others)
- resp_err  out  1  poll timeout (valid with resp_valid)
- spi_data_in  out  8  to master data_in
- spi_address  out  24  to master address
- spi_command  out  8  to master command
- spi_validflag  out  1  to master validflag, one-cycle pulse
- spi_tofrom_fl  out  1  to master tofrom_fl, 1=write frame, 0=read frame
- spi_data_out  in  8  from master data_out
- spi_validflag_out  in  1  from master, read byte valid
- spi_tready  in  1  from master, idle

Behaviour:
- Reset (rst=0, async): state IDLE; req_ready=1; resp_valid=0, resp_data=0, resp_err=0; spi_validflag=0, spi_tofrom_fl=0; spi_command/address/data_in=0; step and poll counter cleared.
- Request accept: req_valid&req_ready in IDLE latches op, addr, data; req_ready drops the next cycle and stays low until the cycle after resp_valid.
- Step lists:
  - READ: {CMD_READ rd}
  - PROGRAM: {CMD_WREN wr, CMD_PP wr, CMD_RDSR rd loop}
  - ERASE: {CMD_WREN wr, CMD_SE wr, CMD_RDSR rd loop}
  - RDSR: {CMD_RDSR rd}
  - "wr" means spi_tofrom_fl=1; "rd" means spi_tofrom_fl=0.
- Frame contents: spi_address = latched addr for PP/SE/READ, 0 otherwise. spi_data_in = latched data for PP, 0 otherwise.
- FSM states:
  - IDLE: waits for an accepted request.
  - ISSUE: waits for spi_tready=1, then asserts spi_validflag for exactly 1 clk with command fields stable. Fields are held until the next ISSUE.
  - WAIT_BUSY: waits for spi_tready=0. The master updates tready on sclk, so this takes several clks.
  - WAIT_DONE: waits for spi_tready=1.
    - For rd frames, data is captured into an internal byte on the spi_validflag_out pulse, which may occur before or during WAIT_DONE. A pulse seen in any non-IDLE state is captured.
    - On spi_tready=1: go to NEXT.
  - NEXT:
    - wr step with more steps: advance step, go to ISSUE.
    - RDSR loop step with captured[WIP_BIT]=1: reissue RDSR (ISSUE), incrementing the poll counter.
    - RDSR loop step with WIP=0: go to RESP.
    - Last non-loop step: go to RESP.
  - RESP: resp_valid=1 for 1 clk, resp_data = captured byte, resp_err=0; then IDLE.
- spi_validflag is never asserted while spi_tready=0. There is never more than one outstanding frame.
- req_valid while busy is ignored; no queueing.
- An undefined sequence cannot occur: all 4 op codes are defined.
- Reset mid-operation returns to IDLE immediately. The flash frame in flight is not aborted by this block.

Optional Feature:
- Macro: SPI_FL_SEQ_TIMEOUT_EN.
- Defined: a 16-bit poll counter counts RDSR reissues within the loop. When the count reaches POLL_MAX with WIP still 1, go to RESP with resp_err=1 and resp_data = last status byte. The counter is cleared at request accept.
- Undefined: polling is unbounded; resp_err is tied to 0 and no counter is synthesized.

Test Plan:
- READ op=0, addr=24'h012345, flash model returns 8'hA5 → one frame cmd 8'h03 addr 24'h012345 tofrom=0; resp_valid with resp_data=8'hA5, resp_err=0; req_ready back to 1 the cycle after.
- PROGRAM op=1, addr=24'h000100, data=8'h3C, model WIP=1 for 3 polls → frames in order: 06 (wr), 02 addr 000100 data 3C (wr), 05 ×4 (rd); resp_data=8'h00.
- ERASE op=2, addr=24'h001000, WIP cleared at first poll → frames 06, 20 addr 001000, 05 ×1; exactly one resp_valid pulse.
- Handshake: hold spi_tready=0 for 50 clks before each frame → spi_validflag asserted only when tready=1, always a 1-clk pulse; a second req_valid during the busy period is ignored.
- With SPI_FL_SEQ_TIMEOUT_EN and POLL_MAX=4, model WIP stuck at 1 → exactly 5 RDSR frames (initial + 4 reissues), then resp_err=1, resp_data=8'h01.
- Assert rst=0 during WAIT_DONE of a PP step → req_ready=1, resp_valid=0, spi_validflag=0 immediately; after release a READ completes normally.
